// File: rtl/storeque_fwd_pkg.sv
// Shared store-queue types: pointer and entry layout plus the flag-aware age compare.
package storeque_fwd_pkg;

    localparam int SQ_DEPTH = 16;
    localparam int SQ_IDX_W = $clog2(SQ_DEPTH);

    typedef logic [39:0]                 paddr_t;
    typedef logic [$bits(paddr_t)-1:3]   pline_t;
    typedef logic [5:0]                  lqIdx_t;
    typedef logic [SQ_IDX_W:0]           sqIdx_t;

    typedef struct packed {
        logic         vld;
        logic         addrVld;
        logic         dataVld;
        logic         committed;
        logic [63:3]  vaddr;
        pline_t       paddr;
        logic [7:0]   mask;
        logic [63:0]  data;
    } sqEntry_t;

    // True when pointer a is strictly older than pointer b; the MSB is the wrap flag.
    function automatic logic sq_older(input sqIdx_t a, input sqIdx_t b);
        if (a[SQ_IDX_W] == b[SQ_IDX_W]) begin
            return a[SQ_IDX_W-1:0] < b[SQ_IDX_W-1:0];
        end
        return a[SQ_IDX_W-1:0] > b[SQ_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/stfwd_if.sv
// Load-pipeline to store-queue forwarding interface; the store queue is the responder (modport s).
interface stfwd_if;
    import storeque_fwd_pkg::*;

    logic        s0_vld;
    lqIdx_t      s0_lqIdx;
    sqIdx_t      s0_sqIdx;
    logic [63:0] s0_vaddr;
    logic [7:0]  s0_load_vec;
    logic        s1_vld;
    paddr_t      s1_paddr;

    logic        s1_vaddr_match;
    logic        s1_data_rdy;
    logic [7:0]  s2_match_vec;
    logic [63:0] s2_fwd_data;
    logic        s2_match_failed;

    modport s (
        input  s0_vld, s0_lqIdx, s0_sqIdx, s0_vaddr, s0_load_vec, s1_vld, s1_paddr,
        output s1_vaddr_match, s1_data_rdy, s2_match_vec, s2_fwd_data, s2_match_failed
    );

    modport m (
        output s0_vld, s0_lqIdx, s0_sqIdx, s0_vaddr, s0_load_vec, s1_vld, s1_paddr,
        input  s1_vaddr_match, s1_data_rdy, s2_match_vec, s2_fwd_data, s2_match_failed
    );

endinterface

// File: rtl/storeque_fwd_age_sel.sv
// Per-byte youngest-candidate selection: scans from head toward tail so the last hit wins.
module sq_age_sel
    import storeque_fwd_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH
) (
    input  logic [DEPTH-1:0]         candVec_i,
    input  logic [$clog2(DEPTH)-1:0] headIdx_i,
    input  logic [7:0]               loadVec_i,
    input  logic [DEPTH-1:0][7:0]    entryMask_i,
    input  logic [DEPTH-1:0][63:0]   entryData_i,
    output logic [7:0]               hitVec_o,
    output logic [63:0]              byteData_o,
    output logic [7:0][DEPTH-1:0]    selOh_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] scanIdx;

    always_comb begin
        hitVec_o   = '0;
        byteData_o = '0;
        selOh_o    = '0;
        scanIdx    = '0;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < DEPTH; k++) begin
                scanIdx = headIdx_i + IDX_W'(k);
                if (candVec_i[scanIdx] && entryMask_i[scanIdx][b] && loadVec_i[b]) begin
                    hitVec_o[b]           = 1'b1;
                    byteData_o[b*8 +: 8]  = entryData_i[scanIdx][b*8 +: 8];
                    selOh_o[b]            = '0;
                    selOh_o[b][scanIdx]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/storeque_fwd.sv
// Store queue: in-order allocate/commit/drain with a three-stage store-to-load forwarding responder.
module storeque_fwd
    import storeque_fwd_pkg::*;
#(
    parameter int DEPTH   = SQ_DEPTH,
    parameter int PADDR_W = $bits(paddr_t)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enq_vld,
    output logic               o_enq_rdy,
    output sqIdx_t             o_enq_sqIdx,
    input  logic               i_sta_vld,
    input  sqIdx_t             i_sta_sqIdx,
    input  logic [63:0]        i_sta_vaddr,
    input  logic [PADDR_W-1:0] i_sta_paddr,
    input  logic [7:0]         i_sta_mask,
    input  logic               i_std_vld,
    input  sqIdx_t             i_std_sqIdx,
    input  logic [63:0]        i_std_data,
    input  logic               i_commit_vld,
    input  logic               i_flush,
    output logic               o_drain_vld,
    output logic [PADDR_W-1:0] o_drain_paddr,
    output logic [63:0]        o_drain_data,
    output logic [7:0]         o_drain_mask,
    input  logic               i_drain_rdy,
    stfwd_if.s                 if_stfwd
);

    localparam int IDX_W = $clog2(DEPTH);

    sqEntry_t entry_q [DEPTH];
    sqEntry_t entry_d [DEPTH];
    sqIdx_t   head_q, head_d;
    sqIdx_t   cmt_q, cmt_d;
    sqIdx_t   tail_q, tail_d;

    logic [IDX_W-1:0] headIdx, cmtIdx, tailIdx, staIdx, stdIdx;
    logic             full, enqFire, drainFire;
    sqIdx_t           entryPtr [DEPTH];

    logic         s0Vld_q;
    sqIdx_t       s0SqIdx_q;
    logic [63:3]  s0Vaddr_q;
    logic [7:0]   s0LoadVec_q;

    logic [DEPTH-1:0]        candVec, older;
    logic [DEPTH-1:0][7:0]   entryMask;
    logic [DEPTH-1:0][63:0]  entryData;
    logic                    s1Match, s1AllData, aliasHit;
    logic [7:0]              hitVec;
    logic [63:0]             byteData;
    logic [7:0][DEPTH-1:0]   selOh;
    pline_t                  selPaddr_d [8];

    logic         s1Vld_q;
    logic [7:0]   hitVec_q;
    logic [63:0]  byteData_q;
    pline_t       selPaddr_q [8];
    pline_t       s1Paddr_q;
    logic         aliasHit_q;
    logic         paddrMiss;

    logic unusedBits;

    assign headIdx = head_q[IDX_W-1:0];
    assign cmtIdx  = cmt_q[IDX_W-1:0];
    assign tailIdx = tail_q[IDX_W-1:0];
    assign staIdx  = i_sta_sqIdx[IDX_W-1:0];
    assign stdIdx  = i_std_sqIdx[IDX_W-1:0];

    assign full        = (headIdx == tailIdx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign o_enq_rdy   = !full;
    assign o_enq_sqIdx = tail_q;
    assign enqFire     = i_enq_vld && o_enq_rdy && !i_flush;

    assign o_drain_vld   = entry_q[headIdx].vld && entry_q[headIdx].committed &&
                           entry_q[headIdx].addrVld && entry_q[headIdx].dataVld;
    assign o_drain_paddr = {entry_q[headIdx].paddr, 3'b000};
    assign o_drain_data  = entry_q[headIdx].data;
    assign o_drain_mask  = entry_q[headIdx].mask;
    assign drainFire     = o_drain_vld && i_drain_rdy;

    assign unusedBits = ^{if_stfwd.s0_lqIdx, if_stfwd.s0_vaddr[2:0], if_stfwd.s1_paddr[2:0],
                          i_sta_vaddr[2:0], i_sta_paddr[2:0], i_sta_sqIdx[IDX_W], i_std_sqIdx[IDX_W]};

    // Live entries sit in [head, head+DEPTH); slots below the head index belong to the next wrap.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entryPtr[i] = {(IDX_W'(i) >= headIdx) ? head_q[IDX_W] : ~head_q[IDX_W], IDX_W'(i)};
        end
    end

    always_comb begin
        head_d = head_q;
        cmt_d  = cmt_q;
        tail_d = tail_q;
        if (drainFire) begin
            head_d = head_q + sqIdx_t'(1);
        end
        if (i_commit_vld) begin
            cmt_d = cmt_q + sqIdx_t'(1);
        end
        if (i_flush) begin
            tail_d = cmt_d;
        end else if (enqFire) begin
            tail_d = tail_q + sqIdx_t'(1);
        end
    end

    always_comb begin
        entry_d = entry_q;
        if (i_sta_vld && entry_q[staIdx].vld) begin
            entry_d[staIdx].vaddr   = i_sta_vaddr[63:3];
            entry_d[staIdx].paddr   = i_sta_paddr[PADDR_W-1:3];
            entry_d[staIdx].mask    = i_sta_mask;
            entry_d[staIdx].addrVld = 1'b1;
        end
        if (i_std_vld && entry_q[stdIdx].vld) begin
            entry_d[stdIdx].data    = i_std_data;
            entry_d[stdIdx].dataVld = 1'b1;
        end
        if (i_commit_vld) begin
            entry_d[cmtIdx].committed = 1'b1;
        end
        if (drainFire) begin
            entry_d[headIdx].vld = 1'b0;
        end
        if (enqFire) begin
            entry_d[tailIdx].vld       = 1'b1;
            entry_d[tailIdx].addrVld   = 1'b0;
            entry_d[tailIdx].dataVld   = 1'b0;
            entry_d[tailIdx].committed = 1'b0;
        end
        // Anything at or beyond the post-commit pointer is speculative and gets squashed.
        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!sq_older(entryPtr[i], cmt_d)) begin
                    entry_d[i].vld = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            entry_q <= entry_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0Vld_q     <= 1'b0;
            s0SqIdx_q   <= '0;
            s0Vaddr_q   <= '0;
            s0LoadVec_q <= '0;
        end else begin
            s0Vld_q     <= if_stfwd.s0_vld;
            s0SqIdx_q   <= if_stfwd.s0_sqIdx;
            s0Vaddr_q   <= if_stfwd.s0_vaddr[63:3];
            s0LoadVec_q <= if_stfwd.s0_load_vec;
        end
    end

    always_comb begin
        candVec   = '0;
        older     = '0;
        entryMask = '0;
        entryData = '0;
        aliasHit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            entryMask[i] = entry_q[i].mask;
            entryData[i] = entry_q[i].data;
            older[i]     = s0Vld_q && entry_q[i].vld && entry_q[i].addrVld &&
                           sq_older(entryPtr[i], s0SqIdx_q) &&
                           ((entry_q[i].mask & s0LoadVec_q) != 8'h00);
            candVec[i]   = older[i] && (entry_q[i].vaddr == s0Vaddr_q);
            if (older[i] && (entry_q[i].paddr == if_stfwd.s1_paddr[PADDR_W-1:3]) &&
                (entry_q[i].vaddr != s0Vaddr_q)) begin
                aliasHit = 1'b1;
            end
        end
    end

    always_comb begin
        s1AllData = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (candVec[i] && !entry_q[i].dataVld) begin
                s1AllData = 1'b0;
            end
        end
    end

    assign s1Match                 = |candVec;
    assign if_stfwd.s1_vaddr_match = s1Match;
    assign if_stfwd.s1_data_rdy    = s1Match && s1AllData;

    sq_age_sel #(
        .DEPTH (DEPTH)
    ) u_age_sel (
        .candVec_i   (candVec),
        .headIdx_i   (headIdx),
        .loadVec_i   (s0LoadVec_q),
        .entryMask_i (entryMask),
        .entryData_i (entryData),
        .hitVec_o    (hitVec),
        .byteData_o  (byteData),
        .selOh_o     (selOh)
    );

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            selPaddr_d[b] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (selOh[b][e]) begin
                    selPaddr_d[b] = selPaddr_d[b] | entry_q[e].paddr;
                end
            end
        end
    end

    // Snapshot everything the s2 result needs so later drains or flushes cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1Vld_q    <= 1'b0;
            hitVec_q   <= '0;
            byteData_q <= '0;
            s1Paddr_q  <= '0;
            aliasHit_q <= 1'b0;
            for (int b = 0; b < 8; b++) begin
                selPaddr_q[b] <= '0;
            end
        end else begin
            s1Vld_q    <= if_stfwd.s1_vld;
            hitVec_q   <= hitVec;
            byteData_q <= byteData;
            s1Paddr_q  <= if_stfwd.s1_paddr[PADDR_W-1:3];
            aliasHit_q <= aliasHit;
            for (int b = 0; b < 8; b++) begin
                selPaddr_q[b] <= selPaddr_d[b];
            end
        end
    end

    always_comb begin
        paddrMiss = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (hitVec_q[b] && (selPaddr_q[b] != s1Paddr_q)) begin
                paddrMiss = 1'b1;
            end
        end
    end

    assign if_stfwd.s2_match_vec    = s1Vld_q ? hitVec_q : 8'h00;
    assign if_stfwd.s2_fwd_data     = s1Vld_q ? byteData_q : 64'h0;
    assign if_stfwd.s2_match_failed = s1Vld_q && (paddrMiss || aliasHit_q);

    property commitHasEntry;
        @(posedge clk) disable iff (!rst) i_commit_vld |-> (cmt_q != tail_q);
    endproperty
    assert property (commitHasEntry);

endmodule
